wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 23 ++
 rtl/wb_rr_picker.sv | 50 +++++
 rtl/wb_arbiter.sv | 64 ++++++
 tb/tb_wb_arbiter.sv | 117 +++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared writeback widths, port count and writeback port record
package wb_arbiter_pkg;

    localparam int AL_IDX_W = 4;
    localparam int PREG_W   = 6;
    localparam int NUM_WB   = 4;

    typedef struct packed {
        logic                valid;
        logic [AL_IDX_W-1:0] al_idx;
        logic [PREG_W-1:0]   rd;
        logic                uses_rd;
    } wb_ifc_t;

    function automatic wb_ifc_t wb_pack(
        input logic [AL_IDX_W-1:0] al_idx,
        input logic [PREG_W-1:0]   rd,
        input logic                uses_rd
    );
        wb_pack = '{valid: 1'b1, al_idx: al_idx, rd: rd, uses_rd: uses_rd};
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// wb_rr_picker: round-robin scan from rr_ptr granting up to NUM_WB requesters in scan order
module wb_rr_picker #(
    parameter int NUM_REQ = 6,
    parameter int NUM_WB  = wb_arbiter_pkg::NUM_WB,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]           valid,
    input  logic [PTR_W-1:0]             rr_ptr,
    output logic [NUM_REQ-1:0]           grant,
    output logic [NUM_WB-1:0]            port_vld,
    output logic [NUM_WB-1:0][PTR_W-1:0] src_idx,
    output logic [PTR_W-1:0]             next_ptr
);

    localparam int CNT_W = $clog2(NUM_WB + 1);

    logic [CNT_W-1:0] cnt;
    logic [PTR_W-1:0] idx;

    function automatic logic [PTR_W-1:0] wrap(input logic [PTR_W-1:0] p, input int j);
        int s;
        s = int'(p) + j;
        return PTR_W'(s >= NUM_REQ ? s - NUM_REQ : s);
    endfunction

    // walk requesters from rr_ptr; the k-th hit goes to port k, the pointer follows the last hit
    always_comb begin
        grant    = '0;
        port_vld = '0;
        src_idx  = '0;
        next_ptr = rr_ptr;
        cnt      = '0;
        idx      = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            idx = wrap(rr_ptr, j);
            if (valid[idx] && cnt < CNT_W'(NUM_WB)) begin
                grant[idx] = 1'b1;
                for (int k = 0; k < NUM_WB; k++) begin
                    if (cnt == CNT_W'(k)) begin
                        port_vld[k] = 1'b1;
                        src_idx[k]  = idx;
                    end
                end
                cnt      = cnt + CNT_W'(1);
                next_ptr = wrap(idx, 1);
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbitration of completion requesters onto registered writeback ports
module wb_arbiter import wb_arbiter_pkg::*; #(
    parameter int NUM_REQ = 6,
    parameter int NUM_WB  = wb_arbiter_pkg::NUM_WB,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              ext_flush,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0][AL_IDX_W-1:0]  req_al_idx,
    input  logic [NUM_REQ-1:0][PREG_W-1:0]    req_rd,
    input  logic [NUM_REQ-1:0]                req_uses_rd,
    output logic [NUM_REQ-1:0]                req_ready,
    output wb_ifc_t [NUM_WB-1:0]              o_wb
);

    logic [NUM_REQ-1:0]           pick_valid;
    logic [NUM_REQ-1:0]           grant;
    logic [NUM_WB-1:0]            port_vld;
    logic [NUM_WB-1:0][PTR_W-1:0] src_idx;
    logic [PTR_W-1:0]             next_ptr;
    logic [PTR_W-1:0]             rr_ptr_d, rr_ptr_q;
    wb_ifc_t [NUM_WB-1:0]         wb_d, wb_q;

    // reset and flush hide every request so nothing is granted and the pointer holds
    assign pick_valid = (reset || ext_flush) ? '0 : req_valid;
    assign req_ready  = grant;
    assign o_wb       = wb_q;

    wb_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .NUM_WB  (NUM_WB),
        .PTR_W   (PTR_W)
    ) u_picker (
        .valid    (pick_valid),
        .rr_ptr   (rr_ptr_q),
        .grant    (grant),
        .port_vld (port_vld),
        .src_idx  (src_idx),
        .next_ptr (next_ptr)
    );

    // route each granted requester's fields to its port; idle ports carry all zeros
    always_comb begin
        rr_ptr_d = |grant ? next_ptr : rr_ptr_q;
        wb_d     = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            wb_d[k] = port_vld[k] ? wb_pack(req_al_idx[src_idx[k]], req_rd[src_idx[k]], req_uses_rd[src_idx[k]]) : '0;
        end
    end

    // pointer and writeback registers; reset discards anything already registered
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
            wb_q     <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wb_q     <= wb_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scoreboard bench for the writeback arbiter
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    typedef wb_ifc_t [3:0] wbv_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            ext_flush;
    logic [5:0]      req_valid;
    logic [5:0][3:0] req_al_idx;
    logic [5:0][5:0] req_rd;
    logic [5:0]      req_uses_rd;
    logic [5:0]      req_ready;
    wbv_t            o_wb;

    logic [3:0] al_tab [6] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h5, 4'h6};
    logic [5:0] rd_tab [6] = '{6'd11, 6'd12, 6'd13, 6'd37, 6'd15, 6'd16};
    logic [5:0] use_tab    = 6'b110111;

    wbv_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .ext_flush   (ext_flush),
        .req_valid   (req_valid),
        .req_al_idx  (req_al_idx),
        .req_rd      (req_rd),
        .req_uses_rd (req_uses_rd),
        .req_ready   (req_ready),
        .o_wb        (o_wb)
    );

    task automatic step(input string tag, input logic r, input logic fl, input logic [5:0] v,
                        input int g0, input int g1, input int g2, input int g3, input int ptr);
        int         g[4];
        logic [5:0] rdy;
        wbv_t       e;
        wbv_t       got;
        g   = '{g0, g1, g2, g3};
        rdy = '0;
        e   = '0;
        for (int k = 0; k < 4; k++) begin
            if (g[k] >= 0) begin
                rdy[g[k]] = 1'b1;
                e[k] = '{valid: 1'b1, al_idx: al_tab[g[k]], rd: rd_tab[g[k]], uses_rd: use_tab[g[k]]};
            end
        end
        reset     = r;
        ext_flush = fl;
        req_valid = v;
        exp_q.push_back(e);
        #1;
        checks++;
        assert (req_ready === rdy) else begin
            errors++;
            $error("FAIL %s ready got %b exp %b", tag, req_ready, rdy);
        end
        checks++;
        assert ((req_ready & ~v) === 6'b0) else begin
            errors++;
            $error("FAIL %s ready_without_valid got %b exp 000000", tag, req_ready & ~v);
        end
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            got = exp_q.pop_front();
            assert (o_wb === got) else begin
                errors++;
                $error("FAIL %s o_wb got %h exp %h", tag, o_wb, got);
            end
        end
        checks++;
        assert (dut.rr_ptr_q === 3'(ptr)) else begin
            errors++;
            $error("FAIL %s rr_ptr got %0d exp %0d", tag, dut.rr_ptr_q, ptr);
        end
    endtask

    initial begin
        for (int i = 0; i < 6; i++) begin
            req_al_idx[i] = al_tab[i];
            req_rd[i]     = rd_tab[i];
        end
        req_uses_rd = use_tab;
        reset       = 1'b1;
        ext_flush   = 1'b0;
        req_valid   = '0;
        step("reset_hold",  1'b1, 1'b0, 6'b111111, -1, -1, -1, -1, 0);
        step("two_low",     1'b0, 1'b0, 6'b000011,  0,  1, -1, -1, 2);
        step("upper_four",  1'b0, 1'b0, 6'b111100,  2,  3,  4,  5, 0);
        step("all_a",       1'b0, 1'b0, 6'b111111,  0,  1,  2,  3, 4);
        step("all_b",       1'b0, 1'b0, 6'b111111,  4,  5,  0,  1, 2);
        step("all_c",       1'b0, 1'b0, 6'b111111,  2,  3,  4,  5, 0);
        step("req3_no_rd",  1'b0, 1'b0, 6'b001000,  3, -1, -1, -1, 4);
        step("wrap",        1'b0, 1'b0, 6'b110001,  4,  5,  0, -1, 1);
        step("pre_flush",   1'b0, 1'b0, 6'b000110,  1,  2, -1, -1, 3);
        step("flush",       1'b0, 1'b1, 6'b111111, -1, -1, -1, -1, 3);
        step("idle",        1'b0, 1'b0, 6'b000000, -1, -1, -1, -1, 3);
        step("four_from3",  1'b0, 1'b0, 6'b111111,  3,  4,  5,  0, 1);
        step("reset_mid",   1'b1, 1'b0, 6'b111111, -1, -1, -1, -1, 0);
        step("last_only",   1'b0, 1'b0, 6'b100000,  5, -1, -1, -1, 0);
        step("first_only",  1'b0, 1'b0, 6'b000001,  0, -1, -1, -1, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
